// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared forward-select encodings, mult/div FSM states and register-match helper.
package mips_hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    // $0 is hardwired zero, so it never produces a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker: tracks occupancy of the multi-cycle mult/div unit after an accepted issue.
module md_busy_tracker
    import mips_hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic busy
);

    localparam int W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    md_state_t state;
    logic [W-1:0] mdcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            mdcnt <= '0;
        end else if (state == MD_IDLE) begin
            if (issue) begin
                state <= MD_BUSY;
                mdcnt <= W'(MD_LATENCY - 1);
            end
        end else begin
            mdcnt <= (mdcnt == '0) ? '0 : mdcnt - 1'b1;
            if (mdcnt == '0) state <= MD_IDLE;
        end
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush/forward control, mult/div occupancy and stall-cycle counter.
module hazard_controller
    import mips_hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           RsD,
    input  logic [4:0]           RtD,
    input  logic [4:0]           RsE,
    input  logic [4:0]           RtE,
    input  logic [4:0]           WriteRegE,
    input  logic [4:0]           WriteRegM,
    input  logic [4:0]           WriteRegW,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegE,
    input  logic                 MemtoRegM,
    input  logic                 BranchD,
    input  logic                 MdStartD,
    input  logic                 HiLoReadD,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushE,
    output logic                 ForwardAD,
    output logic                 ForwardBD,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 MdBusy,
    output logic [CNT_WIDTH-1:0] StallCnt
);

    logic lwstall, branchstall, mdstall, stall;

    always_comb begin
        ForwardAE = (RegWriteM && reg_hit(RsE, WriteRegM)) ? FWD_MEM :
                    (RegWriteW && reg_hit(RsE, WriteRegW)) ? FWD_WB  : FWD_REG;
        ForwardBE = (RegWriteM && reg_hit(RtE, WriteRegM)) ? FWD_MEM :
                    (RegWriteW && reg_hit(RtE, WriteRegW)) ? FWD_WB  : FWD_REG;
        ForwardAD = RegWriteM && reg_hit(RsD, WriteRegM);
        ForwardBD = RegWriteM && reg_hit(RtD, WriteRegM);
        lwstall = MemtoRegE && (reg_hit(RsD, RtE) || reg_hit(RtD, RtE));
        // Branches resolve in Decode, so an ALU result still in E or a load in M is too late.
        branchstall = BranchD &&
                      ((RegWriteE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE))) ||
                       (MemtoRegM && (reg_hit(RsD, WriteRegM) || reg_hit(RtD, WriteRegM))));
        mdstall = (MdStartD || HiLoReadD) && MdBusy;
        stall = lwstall || branchstall || mdstall;
    end

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    md_busy_tracker #(.MD_LATENCY(MD_LATENCY)) u_md (
        .clk   (clk),
        .reset (reset),
        .issue (MdStartD && !stall),
        .busy  (MdBusy)
    );

    always_ff @(posedge clk) begin
        if (reset) StallCnt <= '0;
        else if (stall && !(&StallCnt)) StallCnt <= StallCnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors plus a rule-level model checked every cycle.
module tb_hazard_controller;

    localparam int LAT = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] RsD = 0, RtD = 0, RsE = 0, RtE = 0, WriteRegE = 0, WriteRegM = 0, WriteRegW = 0;
    logic RegWriteE = 0, RegWriteM = 0, RegWriteW = 0, MemtoRegE = 0, MemtoRegM = 0;
    logic BranchD = 0, MdStartD = 0, HiLoReadD = 0;
    logic StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CW-1:0] StallCnt;

    int checks = 0;
    int fails = 0;
    int rem = 0;
    int cnt = 0;
    bit started = 0;

    hazard_controller #(.MD_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MdStartD(MdStartD), .HiLoReadD(HiLoReadD), .StallF(StallF), .StallD(StallD),
        .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MdBusy(MdBusy), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    function automatic bit same(input logic [4:0] a, input logic [4:0] b);
        return a != 0 && a == b;
    endfunction

    function automatic logic [1:0] m_fwd_e(input logic [4:0] r);
        if (RegWriteM && same(r, WriteRegM)) return 2'b10;
        if (RegWriteW && same(r, WriteRegW)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        bit lw, br, md;
        lw = MemtoRegE && (same(RtE, RsD) || same(RtE, RtD));
        br = BranchD && ((RegWriteE && (same(WriteRegE, RsD) || same(WriteRegE, RtD))) ||
                         (MemtoRegM && (same(WriteRegM, RsD) || same(WriteRegM, RtD))));
        md = (MdStartD || HiLoReadD) && rem > 0;
        return lw || br || md;
    endfunction

    // rem counts busy cycles still ahead; cnt is the ideal saturating stall tally.
    always @(posedge clk) begin
        if (reset) begin
            rem <= 0;
            cnt <= 0;
            started <= 1;
        end else begin
            if (m_stall()) cnt <= (cnt == (1 << CW) - 1) ? cnt : cnt + 1;
            if (rem > 0) rem <= rem - 1;
            else if (MdStartD && !m_stall()) rem <= LAT;
        end
    end

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp("model_fwd_e", {ForwardAE, ForwardBE}, {m_fwd_e(RsE), m_fwd_e(RtE)});
            cmp("model_fwd_d", {ForwardAD, ForwardBD},
                {RegWriteM && same(RsD, WriteRegM), RegWriteM && same(RtD, WriteRegM)});
            cmp("model_stall", {StallF, StallD, FlushE}, {3{m_stall()}});
            cmp("model_busy", MdBusy, rem > 0);
            cmp("model_cnt", StallCnt, cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clr();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MdStartD, HiLoReadD} = '0;
    endtask

    initial begin
        repeat (2) cyc();
        reset = 0;
        settle();
        cmp("reset_cnt", StallCnt, 0);
        cmp("reset_busy", MdBusy, 0);
        // forwarding priority and $0
        cyc();
        RegWriteM = 1; WriteRegM = 8; RsE = 8; RegWriteW = 1; WriteRegW = 8;
        settle();
        cmp("fwd_mem_prio", ForwardAE, 2'b10);
        cyc();
        RsE = 0;
        settle();
        cmp("fwd_r0", ForwardAE, 2'b00);
        cyc();
        RegWriteM = 0; RtE = 8;
        settle();
        cmp("fwd_wb", ForwardBE, 2'b01);
        // load-use stall
        cyc(); clr();
        MemtoRegE = 1; RtE = 9; RsD = 9;
        settle();
        cmp("lw_stall", {StallF, StallD, FlushE}, 3'b111);
        cyc(); clr();
        settle();
        cmp("lw_cnt", StallCnt, 1);
        MemtoRegE = 1;
        settle();
        cmp("lw_r0", StallF, 0);
        // branch stall then Decode forward
        cyc(); clr();
        BranchD = 1; RegWriteE = 1; WriteRegE = 4; RtD = 4;
        settle();
        cmp("br_stall", StallD, 1);
        cyc();
        RegWriteE = 0; RegWriteM = 1; WriteRegM = 4;
        settle();
        cmp("br_release", StallD, 0);
        cmp("br_fwd_bd", ForwardBD, 1);
        // mult/div occupancy
        cyc(); clr();
        MdStartD = 1;
        settle();
        cmp("md_issue_idle", {MdBusy, StallF}, 2'b00);
        cyc();
        MdStartD = 0; HiLoReadD = 1;
        for (int i = 0; i < LAT; i++) begin
            settle();
            cmp($sformatf("md_busy_%0d", i), {MdBusy, StallF}, 2'b11);
            cyc();
        end
        settle();
        cmp("md_release", {MdBusy, StallF}, 2'b00);
        // mult/div blocked by load stall
        cyc(); clr();
        MemtoRegE = 1; RtE = 3; RsD = 3; MdStartD = 1;
        settle();
        cmp("md_lw_stall", StallF, 1);
        cyc();
        MemtoRegE = 0;
        settle();
        cmp("md_not_issued", {MdBusy, StallF}, 2'b00);
        cyc();
        MdStartD = 0;
        settle();
        cmp("md_late_issue", MdBusy, 1);
        repeat (LAT + 1) cyc();
        // randomized traffic on a small register window
        for (int i = 0; i < 150; i++) begin
            RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
            RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD} = 6'($urandom);
            MdStartD = ($urandom_range(0, 5) == 0);
            HiLoReadD = ($urandom_range(0, 5) == 0);
            cyc();
        end
        // reset mid-operation, then counter saturation
        clr();
        repeat (LAT + 1) cyc();
        MdStartD = 1;
        cyc();
        MdStartD = 0;
        cyc();
        reset = 1;
        cyc();
        settle();
        cmp("rst_busy", MdBusy, 0);
        cmp("rst_cnt", StallCnt, 0);
        reset = 0;
        MemtoRegE = 1; RtE = 5; RsD = 5;
        repeat (20) cyc();
        clr();
        settle();
        cmp("cnt_sat", StallCnt, 4'hF);
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
